// File: rtl/aqed_fifo_dup_checker.sv
// A-QED duplicate checker for a FIFO-mode memory core: pairs an original write with a
// later identical duplicate write and compares the values the core returns for both.
module aqed_fifo_dup_checker #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 16,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              wen_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_out,
   input  logic [DATA_W-1:0] data_out,
   input  logic              orig_sel,
   input  logic              dup_sel,
   output logic              orig_issued,
   output logic              dup_issued,
   output logic              qed_done,
   output logic              qed_check,
   output logic              occ_err
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ORIG, DUP, DONE} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   state_t              state, state_n;
   logic [CNT_W-1:0]    wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
   logic [OCC_W-1:0]    occ, occ_n;
   logic                orig_seen, orig_seen_n, dup_seen, dup_seen_n;
   logic [DATA_W-1:0]   orig_val, orig_val_n, orig_out, orig_out_n, dup_out, dup_out_n;
   logic [CNT_W-1:0]    orig_idx, orig_idx_n, dup_idx, dup_idx_n;
   logic                cnt_sat, err_set, cap_orig, cap_dup, done_set, check_n;

   assign cnt_sat = (wr_cnt == CNT_MAX) || (rd_cnt == CNT_MAX);

   always_comb begin
      state_n     = state;
      wr_cnt_n    = wen_in    ? sat_inc(wr_cnt) : wr_cnt;
      rd_cnt_n    = valid_out ? sat_inc(rd_cnt) : rd_cnt;
      occ_n       = occ;
      err_set     = 1'b0;
      orig_val_n  = orig_val;
      orig_idx_n  = orig_idx;
      dup_idx_n   = dup_idx;
      orig_out_n  = orig_out;
      dup_out_n   = dup_out;
      orig_seen_n = orig_seen;
      dup_seen_n  = dup_seen;
      cap_orig    = 1'b0;
      cap_dup     = 1'b0;
      done_set    = 1'b0;
      check_n     = 1'b0;

      // A simultaneous write and read cancel; a read at empty is always an error.
      if (wen_in && !valid_out) begin
         if (occ == OCC_FULL) err_set = 1'b1;
         else                 occ_n   = occ + OCC_W'(1);
      end
      if (valid_out) begin
         if (occ == '0)   err_set = 1'b1;
         else if (!wen_in) occ_n  = occ - OCC_W'(1);
      end

      case (state)
         IDLE: begin
            if (wen_in && orig_sel && !cnt_sat) begin
               cap_orig   = 1'b1;
               orig_val_n = data_in;
               orig_idx_n = wr_cnt;
               state_n    = ORIG;
               if (valid_out && rd_cnt == wr_cnt) begin
                  orig_out_n  = data_out;
                  orig_seen_n = 1'b1;
               end
            end
         end
         ORIG: begin
            if (valid_out && rd_cnt == orig_idx) begin
               orig_out_n  = data_out;
               orig_seen_n = 1'b1;
            end
            if (wen_in && dup_sel && data_in == orig_val) begin
               cap_dup   = 1'b1;
               dup_idx_n = wr_cnt;
               state_n   = DUP;
            end
         end
         DUP: begin
            if (valid_out && rd_cnt == orig_idx) begin
               orig_out_n  = data_out;
               orig_seen_n = 1'b1;
            end
            if (valid_out && rd_cnt == dup_idx) begin
               dup_out_n  = data_out;
               dup_seen_n = 1'b1;
            end
            // Completion may coincide with the later of the two output captures.
            if (orig_seen_n && dup_seen_n) begin
               done_set = 1'b1;
               check_n  = (orig_out_n == dup_out_n);
               state_n  = DONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state       <= IDLE;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
         occ         <= '0;
         orig_seen   <= 1'b0;
         dup_seen    <= 1'b0;
         orig_issued <= 1'b0;
         dup_issued  <= 1'b0;
         qed_done    <= 1'b0;
         qed_check   <= 1'b0;
         occ_err     <= 1'b0;
      end else if (clk_en) begin
         state       <= state_n;
         wr_cnt      <= wr_cnt_n;
         rd_cnt      <= rd_cnt_n;
         occ         <= occ_n;
         orig_seen   <= orig_seen_n;
         dup_seen    <= dup_seen_n;
         orig_issued <= orig_issued | cap_orig;
         dup_issued  <= dup_issued | cap_dup;
         qed_done    <= qed_done | done_set;
         qed_check   <= done_set ? check_n : qed_check;
         occ_err     <= occ_err | err_set;
      end
   end

   // Captured values are only consulted behind the state and seen flags, so they need no reset.
   always_ff @(posedge clk) begin
      if (clk_en) begin
         orig_val <= orig_val_n;
         orig_idx <= orig_idx_n;
         dup_idx  <= dup_idx_n;
         orig_out <= orig_out_n;
         dup_out  <= dup_out_n;
      end
   end

endmodule

// File: tb/tb_aqed_fifo_dup_checker.sv
// Bench for aqed_fifo_dup_checker: directed scenarios plus randomized traffic against a
// cycle-level reference model of the checker rules.
module tb_aqed_fifo_dup_checker;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 6;
   localparam int DEPTH  = 4;
   localparam int MAXC   = 63;

   logic clk = 1'b0;
   logic reset, clk_en, flush, wen_in, valid_out, orig_sel, dup_sel;
   logic [DATA_W-1:0] data_in, data_out;
   logic orig_issued, dup_issued, qed_done, qed_check, occ_err;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_wr, m_rd, m_occ, m_phase, m_oidx, m_didx;
   bit m_err, m_oseen, m_dseen, m_oiss, m_diss, m_done, m_chk;
   logic [DATA_W-1:0] m_oval, m_oout, m_dout;

   aqed_fifo_dup_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
      .wen_in(wen_in), .data_in(data_in), .valid_out(valid_out), .data_out(data_out),
      .orig_sel(orig_sel), .dup_sel(dup_sel),
      .orig_issued(orig_issued), .dup_issued(dup_issued),
      .qed_done(qed_done), .qed_check(qed_check), .occ_err(occ_err)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit sat;
      if (reset || flush) begin
         m_wr = 0; m_rd = 0; m_occ = 0; m_phase = 0; m_err = 0;
         m_oseen = 0; m_dseen = 0; m_oiss = 0; m_diss = 0; m_done = 0; m_chk = 0;
      end else if (clk_en) begin
         sat = (m_wr == MAXC) || (m_rd == MAXC);
         if (m_phase == 0) begin
            if (wen_in && orig_sel && !sat) begin
               m_oval = data_in; m_oidx = m_wr; m_phase = 1; m_oiss = 1;
               if (valid_out && m_rd == m_wr) begin m_oout = data_out; m_oseen = 1; end
            end
         end else if (m_phase == 1) begin
            if (valid_out && m_rd == m_oidx) begin m_oout = data_out; m_oseen = 1; end
            if (wen_in && dup_sel && data_in == m_oval) begin
               m_didx = m_wr; m_phase = 2; m_diss = 1;
            end
         end else if (m_phase == 2) begin
            if (valid_out && m_rd == m_oidx) begin m_oout = data_out; m_oseen = 1; end
            if (valid_out && m_rd == m_didx) begin m_dout = data_out; m_dseen = 1; end
            if (m_oseen && m_dseen) begin
               m_phase = 3; m_done = 1; m_chk = (m_oout == m_dout);
            end
         end
         if (valid_out && m_occ == 0) m_err = 1;
         if (wen_in && !valid_out && m_occ == DEPTH) m_err = 1;
         if (wen_in && !valid_out && m_occ < DEPTH) m_occ++;
         if (valid_out && !wen_in && m_occ > 0) m_occ--;
         if (wen_in && m_wr < MAXC) m_wr++;
         if (valid_out && m_rd < MAXC) m_rd++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; flush = 0; clk_en = 1; wen_in = 0; valid_out = 0;
      orig_sel = 0; dup_sel = 0; data_in = '0; data_out = '0;
   endtask

   task automatic do_reset();
      idle_inputs(); reset = 1; step(); reset = 0;
   endtask

   task automatic wr(input logic [DATA_W-1:0] d, input bit os, input bit ds);
      idle_inputs(); wen_in = 1; data_in = d; orig_sel = os; dup_sel = ds; step(); idle_inputs();
   endtask

   task automatic rd(input logic [DATA_W-1:0] d);
      idle_inputs(); valid_out = 1; data_out = d; step(); idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; clk_en = 1'($urandom); flush = 1'($urandom); wen_in = 1'($urandom);
      valid_out = 1'($urandom); orig_sel = 1'($urandom); dup_sel = 1'($urandom);
      data_in = DATA_W'($urandom); data_out = DATA_W'($urandom);
      step();
      checks++;
      if ({orig_issued, dup_issued, qed_done, qed_check, occ_err} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 00000",
                            {orig_issued, dup_issued, qed_done, qed_check, occ_err});
      end
      idle_inputs();
      repeat (5) step();
      checks++;
      if ({orig_issued, dup_issued, qed_done, qed_check, occ_err} !== 5'b0) begin
         errors++; $display("FAIL reset_idle_outputs: got %b expected 00000",
                            {orig_issued, dup_issued, qed_done, qed_check, occ_err});
      end
   endtask

   task automatic test_pair(input logic [DATA_W-1:0] third, input bit exp_chk, input string nm);
      do_reset();
      wr(8'h11, 1, 0);
      checks++;
      if (orig_issued !== 1'b1) begin errors++; $display("FAIL %s_orig_issued: got %b expected 1", nm, orig_issued); end
      wr(8'h22, 0, 0);
      checks++;
      if (dup_issued !== 1'b0) begin errors++; $display("FAIL %s_dup_early: got %b expected 0", nm, dup_issued); end
      wr(8'h11, 0, 1);
      checks++;
      if (dup_issued !== 1'b1) begin errors++; $display("FAIL %s_dup_issued: got %b expected 1", nm, dup_issued); end
      rd(8'h11);
      rd(8'h22);
      checks++;
      if (qed_done !== 1'b0) begin errors++; $display("FAIL %s_done_early: got %b expected 0", nm, qed_done); end
      rd(third);
      checks++;
      if (qed_done !== 1'b1 || qed_check !== exp_chk) begin
         errors++; $display("FAIL %s_result: got done=%b check=%b expected done=1 check=%b", nm, qed_done, qed_check, exp_chk);
      end
      repeat (3) step();
      checks++;
      if (qed_done !== 1'b1 || qed_check !== exp_chk || occ_err !== 1'b0) begin
         errors++; $display("FAIL %s_hold: got done=%b check=%b err=%b expected 1 %b 0", nm, qed_done, qed_check, occ_err, exp_chk);
      end
   endtask

   task automatic test_mismatched_dup();
      do_reset();
      wr(8'h11, 1, 0);
      wr(8'h12, 0, 1);
      checks++;
      if (dup_issued !== 1'b0) begin errors++; $display("FAIL mismatch_dup_issued: got %b expected 0", dup_issued); end
      rd(8'h11);
      rd(8'h12);
      checks++;
      if (qed_done !== 1'b0 || dup_issued !== 1'b0) begin
         errors++; $display("FAIL mismatch_done: got done=%b dup=%b expected 0 0", qed_done, dup_issued);
      end
   endtask

   task automatic test_occupancy();
      do_reset();
      for (int i = 0; i < 4; i++) wr(8'(i), 0, 0);
      checks++;
      if (occ_err !== 1'b0) begin errors++; $display("FAIL occ_full_ok: got %b expected 0", occ_err); end
      wr(8'h44, 0, 0);
      checks++;
      if (occ_err !== 1'b1) begin errors++; $display("FAIL occ_overflow: got %b expected 1", occ_err); end
      do_reset();
      rd(8'h00);
      checks++;
      if (occ_err !== 1'b1) begin errors++; $display("FAIL occ_underflow: got %b expected 1", occ_err); end
      do_reset();
      for (int i = 0; i < 4; i++) wr(8'(i), 0, 0);
      idle_inputs(); wen_in = 1; valid_out = 1; step();
      idle_inputs(); wen_in = 1; valid_out = 1; step();
      idle_inputs();
      checks++;
      if (occ_err !== 1'b0) begin errors++; $display("FAIL occ_full_rw: got %b expected 0", occ_err); end
      for (int i = 0; i < 4; i++) rd(8'(i));
      checks++;
      if (occ_err !== 1'b0) begin errors++; $display("FAIL occ_drain: got %b expected 0", occ_err); end
   endtask

   task automatic test_flush();
      do_reset();
      wr(8'h55, 1, 0);
      wr(8'h56, 0, 0);
      idle_inputs(); flush = 1; clk_en = 0; step(); idle_inputs();
      checks++;
      if (orig_issued !== 1'b0) begin errors++; $display("FAIL flush_orig_cleared: got %b expected 0", orig_issued); end
      wr(8'h66, 1, 0);
      checks++;
      if (orig_issued !== 1'b1) begin errors++; $display("FAIL flush_new_orig: got %b expected 1", orig_issued); end
      wr(8'h66, 0, 1);
      rd(8'h66);
      rd(8'h66);
      checks++;
      if (qed_done !== 1'b1 || qed_check !== 1'b1 || occ_err !== 1'b0) begin
         errors++; $display("FAIL flush_index0: got done=%b check=%b err=%b expected 1 1 0", qed_done, qed_check, occ_err);
      end
   endtask

   task automatic test_clk_en();
      do_reset();
      wr(8'h11, 1, 0);
      wr(8'h11, 0, 1);
      for (int i = 0; i < 3; i++) begin
         idle_inputs(); clk_en = 0; wen_in = 1'(i); valid_out = 1'(i + 1);
         orig_sel = 1; dup_sel = 1; data_in = 8'h11; data_out = 8'h99; step();
      end
      idle_inputs();
      checks++;
      if ({orig_issued, dup_issued, qed_done, occ_err} !== 4'b1100) begin
         errors++; $display("FAIL clken_hold: got %b expected 1100", {orig_issued, dup_issued, qed_done, occ_err});
      end
      rd(8'h11);
      rd(8'h11);
      checks++;
      if (qed_done !== 1'b1 || qed_check !== 1'b1 || occ_err !== 1'b0) begin
         errors++; $display("FAIL clken_counters: got done=%b check=%b err=%b expected 1 1 0", qed_done, qed_check, occ_err);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < MAXC; i++) begin
         wr(8'h01, 0, 0);
         rd(8'h01);
      end
      wr(8'h07, 1, 0);
      checks++;
      if (orig_issued !== 1'b0 || occ_err !== 1'b0) begin
         errors++; $display("FAIL sat_no_orig: got orig=%b err=%b expected 0 0", orig_issued, occ_err);
      end
   endtask

   task automatic test_random();
      logic [4:0] got, exp;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 199) == 0);
         clk_en    = ($urandom_range(0, 9) != 0);
         wen_in    = ($urandom_range(0, 1) == 0);
         valid_out = ($urandom_range(0, 9) < 4);
         orig_sel  = ($urandom_range(0, 4) == 0);
         dup_sel   = ($urandom_range(0, 2) == 0);
         data_in   = DATA_W'($urandom_range(0, 3));
         data_out  = DATA_W'($urandom_range(0, 3));
         step();
         got = {orig_issued, dup_issued, qed_done, qed_check, occ_err};
         exp = {m_oiss, m_diss, m_done, m_chk, m_err};
         checks++;
         if (got !== exp) begin
            errors++; $display("FAIL random_cycle%0d: got %b expected %b", c, got, exp);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_pair(8'h11, 1'b1, "matching_pair");
      test_pair(8'h33, 1'b0, "corrupted_core");
      test_mismatched_dup();
      test_occupancy();
      test_flush();
      test_clk_en();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
